// File: rtl/alu_ctrl_decode_stage.sv
// alu_ctrl_decode_stage: RV32I decode to ALU control/operand selects, registered with valid/ready and flush
module alu_ctrl_decode_stage #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [31:0]      i_instr,
  input  logic             i_in_valid,
  output logic             o_in_ready,
  input  logic             i_flush,
  output logic             o_out_valid,
  input  logic             i_out_ready,
  output logic [3:0]       o_alu_control,
  output logic             o_alu_src_imm,
  output logic             o_alu_src_pc,
  output logic             o_alu_src_zero,
  output logic             o_is_branch,
  output logic [WIDTH-1:0] o_imm_out,
  output logic             o_illegal
);
  logic [6:0]       w_op, w_f7;
  logic [2:0]       w_f3;
  logic [31:0]      w_imm_i, w_imm_s, w_imm_b, w_imm_u, w_imm_j, w_imm32;
  logic [3:0]       w_arith, w_bcode, w_ctrl;
  logic             w_src_imm, w_src_pc, w_src_zero, w_branch, w_ill, w_accept;
  logic             r_valid, r_src_imm, r_src_pc, r_src_zero, r_branch, r_ill;
  logic [3:0]       r_ctrl;
  logic [WIDTH-1:0] r_imm;

  assign w_op    = i_instr[6:0];
  assign w_f3    = i_instr[14:12];
  assign w_f7    = i_instr[31:25];
  assign w_imm_i = {{20{i_instr[31]}}, i_instr[31:20]};
  assign w_imm_s = {{20{i_instr[31]}}, i_instr[31:25], i_instr[11:7]};
  assign w_imm_b = {{19{i_instr[31]}}, i_instr[31], i_instr[7], i_instr[30:25], i_instr[11:8], 1'b0};
  assign w_imm_u = {i_instr[31:12], 12'b0};
  assign w_imm_j = {{11{i_instr[31]}}, i_instr[31], i_instr[19:12], i_instr[20], i_instr[30:21], 1'b0};

  assign o_in_ready = !r_valid || i_out_ready;
  assign w_accept   = i_in_valid && o_in_ready && !i_flush;

  // Shared funct3 -> ALU code map for register and immediate arithmetic; instr[30] selects sub/sra
  always_comb begin
    case (w_f3)
      3'b000:  w_arith = i_instr[30] ? 4'b0001 : 4'b0000;
      3'b001:  w_arith = 4'b0100;
      3'b010:  w_arith = 4'b0101;
      3'b011:  w_arith = 4'b0110;
      3'b100:  w_arith = 4'b0111;
      3'b101:  w_arith = i_instr[30] ? 4'b1000 : 4'b1001;
      3'b110:  w_arith = 4'b0011;
      default: w_arith = 4'b0010;
    endcase
  end

  // Branch funct3 -> comparison code (funct3 010/011 are rejected in the main decode)
  always_comb begin
    case (w_f3)
      3'b000:  w_bcode = 4'b0001;
      3'b001:  w_bcode = 4'b1100;
      3'b100:  w_bcode = 4'b0101;
      3'b101:  w_bcode = 4'b1010;
      3'b110:  w_bcode = 4'b0110;
      3'b111:  w_bcode = 4'b1011;
      default: w_bcode = 4'b0000;
    endcase
  end

  // Opcode decode into raw control fields and legality
  always_comb begin
    w_ctrl     = 4'b0000;
    w_src_imm  = 1'b0;
    w_src_pc   = 1'b0;
    w_src_zero = 1'b0;
    w_branch   = 1'b0;
    w_ill      = 1'b0;
    w_imm32    = '0;
    case (w_op)
      7'b0110011: begin
        w_ctrl = w_arith;
        w_ill  = !(w_f7 == 7'b0000000 || (w_f7 == 7'b0100000 && (w_f3 == 3'b000 || w_f3 == 3'b101)));
      end
      7'b0010011: begin
        w_ctrl    = w_f3 == 3'b000 ? 4'b0000 : w_arith;
        w_src_imm = 1'b1;
        w_imm32   = w_imm_i;
        w_ill     = (w_f3 == 3'b001 && w_f7 != 7'b0000000) ||
                    (w_f3 == 3'b101 && w_f7 != 7'b0000000 && w_f7 != 7'b0100000);
      end
      7'b0000011: begin
        w_src_imm = 1'b1;
        w_imm32   = w_imm_i;
        w_ill     = !(w_f3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101});
      end
      7'b0100011: begin
        w_src_imm = 1'b1;
        w_imm32   = w_imm_s;
        w_ill     = w_f3 > 3'b010;
      end
      7'b1100011: begin
        w_ctrl   = w_bcode;
        w_branch = 1'b1;
        w_imm32  = w_imm_b;
        w_ill    = w_f3 == 3'b010 || w_f3 == 3'b011;
      end
      7'b0110111: begin
        w_src_zero = 1'b1;
        w_src_imm  = 1'b1;
        w_imm32    = w_imm_u;
      end
      7'b0010111: begin
        w_src_pc  = 1'b1;
        w_src_imm = 1'b1;
        w_imm32   = w_imm_u;
      end
      7'b1101111: begin
        w_src_pc  = 1'b1;
        w_src_imm = 1'b1;
        w_imm32   = w_imm_j;
      end
      7'b1100111: begin
        w_src_imm = 1'b1;
        w_imm32   = w_imm_i;
        w_ill     = w_f3 != 3'b000;
      end
      default: w_ill = 1'b1;
    endcase
  end

  // Pipeline register: flush kills validity, accept loads payload, consume drops validity
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid    <= 1'b0;
      r_ctrl     <= 4'b0000;
      r_src_imm  <= 1'b0;
      r_src_pc   <= 1'b0;
      r_src_zero <= 1'b0;
      r_branch   <= 1'b0;
      r_ill      <= 1'b0;
      r_imm      <= '0;
    end else if (i_flush) begin
      r_valid <= 1'b0;
    end else if (w_accept) begin
      r_valid    <= 1'b1;
      r_ctrl     <= w_ill ? 4'b0000 : w_ctrl;
      r_src_imm  <= !w_ill && w_src_imm;
      r_src_pc   <= !w_ill && w_src_pc;
      r_src_zero <= !w_ill && w_src_zero;
      r_branch   <= !w_ill && w_branch;
      r_ill      <= w_ill;
      r_imm      <= w_ill ? '0 : WIDTH'($signed(w_imm32));
    end else if (i_out_ready) begin
      r_valid <= 1'b0;
    end
  end

  assign o_out_valid    = r_valid;
  assign o_alu_control  = r_ctrl;
  assign o_alu_src_imm  = r_src_imm;
  assign o_alu_src_pc   = r_src_pc;
  assign o_alu_src_zero = r_src_zero;
  assign o_is_branch    = r_branch;
  assign o_illegal      = r_ill;
  assign o_imm_out      = r_imm;
endmodule
